// File: rtl/sensor_stream_arbiter.sv
// Round-robin arbiter that merges single-beat sensor streams onto one AXI4-Stream sink.
// Each beat is tagged with its source index. Muted sources are drained and counted.
module sensor_stream_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC-1:0]        src_enable,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [ID_W-1:0]           m_axis_tid,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [15:0]               drop_count
);

  localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

  typedef enum logic {ARB, SEND} state_t;

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [DATA_W-1:0]   src_data [NUM_SRC];
  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  grant_oh;
  logic                grant_valid;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     scan_id;
  logic [CNT_W-1:0]    drain_cnt;
  logic [16:0]         drop_sum;
  logic [ID_W-1:0]     ptr_next;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
  end

  assign cand = (state == ARB) ? (src_enable & s_axis_tvalid) : '0;

  // First candidate found scanning upward from ptr, wrapping at NUM_SRC.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_id     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_id = ID_W'((int'(ptr) + int'(k)) % int'(NUM_SRC));
      if (!grant_valid && cand[scan_id]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_id;
      end
    end
  end

  assign grant_oh      = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
  assign s_axis_tready = reset ? '0 : (~src_enable | grant_oh);

  assign drain_cnt = CNT_W'($countones(s_axis_tvalid & ~src_enable));
  assign drop_sum  = {1'b0, drop_count} + 17'(drain_cnt);

  assign ptr_next = (int'(m_axis_tid) == int'(NUM_SRC) - 1) ? '0 : m_axis_tid + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB;
      ptr           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tvalid <= 1'b0;
      drop_count    <= '0;
    end else begin
      drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
      case (state)
        ARB: begin
          if (grant_valid) begin
            m_axis_tdata  <= src_data[grant_idx];
            m_axis_tid    <= grant_idx;
            m_axis_tvalid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            ptr           <= ptr_next;
            state         <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_stream_arbiter.sv
// Bench for sensor_stream_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_sensor_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] s_tdata;
  logic [DW-1:0]   src_d [N];
  logic [N-1:0]    s_tvalid, s_tready, en;
  logic [DW-1:0]   m_tdata;
  logic [IW-1:0]   m_tid;
  logic            m_tvalid, m_tready;
  logic [15:0]     drop;

  always #5 clk = ~clk;

  always_comb begin
    s_tdata = '0;
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = src_d[i];
  end

  sensor_stream_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .src_enable(en),
    .m_axis_tdata(m_tdata), .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .drop_count(drop)
  );

  int unsigned vectors = 0, miscompares = 0;

  // Reference model: one pending output beat, a priority pointer, a drop tally.
  bit          known = 0;
  bit          pend = 0;
  logic [DW-1:0] pdata;
  int          pid = 0, mptr = 0;
  int          mdrops = 0;
  logic [N-1:0] exp_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (en[idx] && s_tvalid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic compare();
    int g;
    if (reset) exp_rdy = '0;
    else begin
      exp_rdy = ~en;
      g = find_grant();
      if (known && !pend && g >= 0) exp_rdy[g] = 1'b1;
    end
    if (known || reset) check("tready", s_tready, exp_rdy);
    if (known) begin
      check("tvalid", m_tvalid, pend);
      if (pend) begin
        check("tdata", m_tdata, pdata);
        check("tid", m_tid, pid);
      end
      check("drop_count", drop, mdrops);
    end
  endtask

  task automatic update();
    int g;
    if (reset) begin
      known = 1; pend = 0; mptr = 0; mdrops = 0;
    end else if (known) begin
      mdrops = mdrops + $countones(s_tvalid & ~en);
      if (mdrops > 65535) mdrops = 65535;
      if (pend) begin
        if (m_tready) begin
          pend = 0;
          mptr = (pid + 1) % N;
        end
      end else begin
        g = find_grant();
        if (g >= 0) begin
          pend = 1; pdata = src_d[g]; pid = g;
        end
      end
    end
  endtask

  // Compare and step the model between edges, then advance one clock.
  task automatic tick();
    #2;
    compare();
    update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = '1; s_tvalid = '0; m_tready = 1'b0;
    for (int i = 0; i < N; i++) src_d[i] = '0;
    @(posedge clk); #1;
    tick(); tick();
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tid", m_tid, 2'd0);
    check("rst_drop", drop, 16'h0);
    check("rst_tready", s_tready, 4'b0000);
    reset = 1'b0;
    repeat (7) tick();

    // Single source beat.
    m_tready = 1'b1; s_tvalid = 4'b0010; src_d[1] = 32'h0000_0005;
    #1 check("single_rdy", s_tready, 4'b0010);
    tick();
    s_tvalid = '0;
    #1;
    check("single_tvalid", m_tvalid, 1'b1);
    check("single_tdata", m_tdata, 32'h5);
    check("single_tid", m_tid, 2'd1);
    tick();
    check("single_done", m_tvalid, 1'b0);

    // Round-robin from a fresh pointer with all sources continuously valid.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) src_d[i] = 32'hA0 + i;
    s_tvalid = '1;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("rr_tvalid", m_tvalid, (c % 2) == 0);
      if (c % 2 == 0) begin
        check("rr_tid", m_tid, (c / 2) % N);
        check("rr_tdata", m_tdata, 32'hA0 + (c / 2) % N);
      end
    end

    // Sink stall with a competing source waiting.
    s_tvalid = 4'b0100; src_d[2] = 32'h1234_5678; m_tready = 1'b0;
    tick();
    s_tvalid = 4'b1000; src_d[3] = 32'hB3;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("bp_tdata", m_tdata, 32'h1234_5678);
      check("bp_tid", m_tid, 2'd2);
      check("bp_rdy3", s_tready[3], 1'b0);
      tick();
    end
    m_tready = 1'b1;
    tick();
    check("bp_release_rdy", s_tready, 4'b1000);
    tick();
    s_tvalid = '0;
    #1;
    check("bp_next_tid", m_tid, 2'd3);
    check("bp_next_tdata", m_tdata, 32'hB3);
    tick();

    // Drain of a muted source.
    en = 4'b1101; s_tvalid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1 check("drain_rdy", s_tready, 4'b0010);
      tick();
      check("drain_no_out", m_tvalid, 1'b0);
    end
    s_tvalid = '0;
    #1 check("drain_count", drop, 16'd5);

    // Reset while a beat from source 3 is pending.
    en = '1; s_tvalid = 4'b1000; m_tready = 1'b0; src_d[3] = 32'hCAFE_0003;
    tick();
    s_tvalid = '0;
    #1;
    check("rmid_pre_tvalid", m_tvalid, 1'b1);
    check("rmid_pre_tid", m_tid, 2'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_tvalid", m_tvalid, 1'b0);
    check("rmid_tid", m_tid, 2'd0);
    check("rmid_drop", drop, 16'd0);
    s_tvalid = 4'b0110; m_tready = 1'b1;
    #1 check("rmid_grant", s_tready, 4'b0010);
    tick();
    s_tvalid = 4'b0100;
    tick(); tick(); tick();
    s_tvalid = '0;
    tick();

    // Saturation of the drop counter.
    en = '0; s_tvalid = '1;
    repeat (17500) tick();
    check("sat_drop", drop, 16'hFFFF);
    tick();
    check("sat_hold", drop, 16'hFFFF);
    s_tvalid = '0; en = '1;
    reset = 1'b1; tick(); reset = 1'b0;

    // Randomized traffic; sources hold each beat until the model says it was taken.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) en = N'($urandom);
      m_tready = ($urandom_range(9) < 7);
      reset = ($urandom_range(599) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && exp_rdy[i]) s_tvalid[i] = 1'b0;
        if (!s_tvalid[i] && $urandom_range(99) < 40) begin
          s_tvalid[i] = 1'b1;
          src_d[i] = $urandom;
        end
      end
    end
    reset = 1'b0; s_tvalid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
